// File: rtl/pipeline_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_defs : shared widths, zero-register constant, divider states   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_defs;

    localparam int REGW = 5;
    localparam logic [REGW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_div_seq.sv
// +--------------------------------------------------------------------+
// | div_seq : iterative-divider start/cancel sequencer                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module div_seq
    import cpu_defs::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_stall,
    input  logic div_e,
    input  logic div_done,
    input  logic exc_m,
    output logic div_busy,
    output logic div_start,
    output logic div_cancel
);

    div_state_t state;
    div_state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (div_e && !mem_stall && !exc_m) begin
                    state_nxt = DIV_RUN;
                    div_start = !rst;
                end
            end
            DIV_RUN: begin
                // A committed exception wins over a same-cycle completion.
                if (exc_m && !mem_stall) begin
                    state_nxt  = DIV_IDLE;
                    div_cancel = !rst;
                end else if (div_done) begin
                    state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!mem_stall) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    assign div_busy = ((state == DIV_IDLE) && div_e) || (state == DIV_RUN);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +--------------------------------------------------------------------+
// | pipeline_ctrl : stage enables/clears, hazards, divide, stall count |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
    import cpu_defs::*;
#(
    parameter int REGW = cpu_defs::REGW,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            d_stall,
    input  logic [REGW-1:0] rs_d,
    input  logic [REGW-1:0] rt_d,
    input  logic            branch_d,
    input  logic            regwrite_e,
    input  logic            memtoreg_e,
    input  logic [REGW-1:0] writereg_e,
    input  logic            memtoreg_m,
    input  logic [REGW-1:0] writereg_m,
    input  logic            div_e,
    input  logic            div_done,
    input  logic            exc_m,
    output logic            en_f,
    output logic            en_d,
    output logic            en_e,
    output logic            en_m,
    output logic            en_w,
    output logic            clr_d,
    output logic            clr_e,
    output logic            clr_m,
    output logic            clr_w,
    output logic            div_start,
    output logic            div_cancel,
    output logic            flush,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [REGW-1:0] ZERO = REGW'(ZERO_REG);

    logic mem_stall;
    logic div_busy;
    logic e_hits_d;
    logic m_hits_d;
    logic lu;
    logic br;

    assign mem_stall = i_stall | d_stall;

    assign e_hits_d = (writereg_e != ZERO) && ((writereg_e == rs_d) || (writereg_e == rt_d));
    assign m_hits_d = (writereg_m != ZERO) && ((writereg_m == rs_d) || (writereg_m == rt_d));
    assign lu       = memtoreg_e && e_hits_d;
    assign br       = branch_d && ((regwrite_e && e_hits_d) || (memtoreg_m && m_hits_d));

    div_seq u_div_seq (
        .clk        (clk),
        .rst        (rst),
        .mem_stall  (mem_stall),
        .div_e      (div_e),
        .div_done   (div_done),
        .exc_m      (exc_m),
        .div_busy   (div_busy),
        .div_start  (div_start),
        .div_cancel (div_cancel)
    );

    always_comb begin
        en_f  = 1'b1;
        en_d  = 1'b1;
        en_e  = 1'b1;
        en_m  = 1'b1;
        en_w  = 1'b1;
        clr_d = 1'b0;
        clr_e = 1'b0;
        clr_m = 1'b0;
        clr_w = 1'b0;
        flush = 1'b0;
        if (rst) begin
            // Defaults already describe the reset view.
        end else if (mem_stall) begin
            // Freeze everything; a pending exc_m stays visible because M is held.
            en_f = 1'b0;
            en_d = 1'b0;
            en_e = 1'b0;
            en_m = 1'b0;
            en_w = 1'b0;
        end else if (exc_m) begin
            flush = 1'b1;
            clr_d = 1'b1;
            clr_e = 1'b1;
            clr_m = 1'b1;
            clr_w = 1'b1;
        end else if (div_busy) begin
            en_f  = 1'b0;
            en_d  = 1'b0;
            en_e  = 1'b0;
            clr_m = 1'b1;
        end else if (lu || br) begin
            en_f  = 1'b0;
            en_d  = 1'b0;
            clr_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!en_f) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Sequences the five-stage pipeline registers (F/D, D/E, E/M, M/W and the PC register) by driving a per-stage enable and a per-stage synchronous clear.
- Resolves four kinds of stall and flush: memory stalls, exception flush, multi-cycle divide, and data hazards.
- Owns the start/cancel handshake of the iterative divider.
- Sits beside the datapath and keeps a stall-cycle counter for performance tests.

Parameters:
- REGW, 5, register-index width.
- CNTW, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- i_stall  in  1  instruction fetch outstanding on the bus
- d_stall  in  1  data access outstanding on the bus
- rs_d, rt_d  in  REGW  source registers in D
- branch_d  in  1  branch or jump-register resolving in D
- regwrite_e, memtoreg_e  in  1  control bits of the E instruction
- writereg_e  in  REGW  destination register of E
- memtoreg_m  in  1  load in M
- writereg_m  in  REGW  destination register of M
- div_e  in  1  E holds a div/divu
- div_done  in  1  divider result valid (1-cycle pulse)
- exc_m  in  1  exception committed in M
- en_f, en_d, en_e, en_m, en_w  out  1  stage register enables (en_f drives the PC)
- clr_d, clr_e, clr_m, clr_w  out  1  stage register clears
- div_start  out  1  1-cycle divider launch
- div_cancel  out  1  1-cycle divider abort
- flush  out  1  selects the exception vector for the PC
- stall_cnt  out  CNTW  cycles with en_f=0

Behaviour:
- Reset: all en_* = 1; all clr_*, div_start, div_cancel and flush = 0; stall_cnt = 0; FSM in IDLE. Reset applies mid-divide with no cancel pulse, because the divider is reset too.
- Downstream registers give clear priority over enable; this block may assert clr_x with en_x=0.
- Hazard terms (combinational):
  - lu = memtoreg_e & writereg_e≠0 & (writereg_e==rs_d | writereg_e==rt_d)
  - br = branch_d & [(regwrite_e & writereg_e≠0 & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m≠0 & writereg_m∈{rs_d,rt_d})]
- Divider FSM (IDLE, RUN, DONE):
  - IDLE→RUN when div_e & no mem stall & no exc_m; div_start=1 in that cycle.
  - RUN→DONE on div_done. RUN→IDLE on exc_m & no mem stall, with div_cancel=1.
  - DONE→IDLE in the first cycle with no mem stall; the E instruction advances in that cycle.
  - div_done while in IDLE or DONE is ignored.
- Per-cycle priority, highest first:
  1. mem = i_stall|d_stall: all en_*=0, all clr_*=0, flush=0. FSM may still take RUN→DONE. exc_m is deferred while mem holds and is taken in the first non-stall cycle; it is never dropped, because M is frozen.
  2. exc_m: flush=1; all en_*=1; clr_d=clr_e=clr_m=clr_w=1. The excepting instruction does not write back.
  3. Divide stall (FSM IDLE with div_e, or FSM in RUN): en_f=en_d=en_e=0, en_m=en_w=1, clr_m=1 (bubble into M).
  4. lu|br: en_f=en_d=0, clr_e=1, other en=1.
  5. Otherwise all en_*=1 and all clr_*=0.
- All outputs except stall_cnt are combinational from state and inputs; no added latency. The FSM state is registered.
- div_start and div_cancel are never high in the same cycle.
- stall_cnt increments when en_f=0 and wraps at 2^CNTW−1 → 0.

Decomposition:
- Shared package (cpu_defs): divider FSM state encoding, REGW, and the zero-register constant.
- One natural sub-module, div_seq: the FSM plus div_start/div_cancel generation. It exports div_busy to the stall-priority logic.
- Stall counter and hazard compares stay inline.

Test Plan:
- Load-use: memtoreg_e=1, writereg_e=5, rs_d=5, 1 cycle → en_f=en_d=0, clr_e=1. Next cycle with memtoreg_e=0 → all en=1.
- Divide: div_e=1 → div_start pulse; E held for 34 cycles until div_done at cycle 33; clr_m=1 throughout; DONE cycle all en=1; exactly one div_start.
- Exception mid-divide: exc_m at RUN cycle 10 → div_cancel=1, flush=1, all four clears=1; FSM back in IDLE next cycle.
- d_stall for 5 cycles with exc_m=1 → all en=0, flush=0 for 5 cycles, then flush=1 on cycle 6; stall_cnt +5.
- div_done during d_stall → FSM reaches DONE and holds until d_stall drops, then E advances.
- Reset asserted in RUN → en all 1, FSM IDLE, stall_cnt=0, no div_cancel; preload stall_cnt=2^32−1, one stall → 0.
